// File: rtl/jk_counter_reg.sv
// Multi-bit JK register / modulo up-down counter / parallel-load register.
// State updates on the falling clock edge; tc is a combinational cascade carry.
module jk_counter_reg #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned MODULUS = 800,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_in,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ModeJk   = 2'b00,
    ModeUp   = 2'b01,
    ModeDown = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RST_VAL);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_d;
  logic             wrap_d;
  logic             out_of_range;
  logic             at_top;
  logic             at_zero;

  assign mode_s = mode_e'(mode);

  // Compare in 32 bits so MODULUS = 2^WIDTH never reports out-of-range.
  assign out_of_range = 32'(Q) >= MODULUS;
  assign at_top       = 32'(Q) >= (MODULUS - 1);
  assign at_zero      = (Q == '0);

  assign tc = enable & cnt_in &
              (((mode_s == ModeUp) & at_top) |
               ((mode_s == ModeDown) & (at_zero | out_of_range)));

  always_comb begin
    q_d    = Q;
    wrap_d = 1'b0;
    if (enable) begin
      unique case (mode_s)
        ModeJk: q_d = (J & ~Q) | (~K & Q);
        ModeUp: begin
          if (cnt_in) begin
            if (at_top) begin
              q_d    = '0;
              wrap_d = 1'b1;
            end else begin
              q_d = Q + WIDTH'(1);
            end
          end
        end
        ModeDown: begin
          if (cnt_in) begin
            if (at_zero || out_of_range) begin
              q_d    = MaxVal;
              wrap_d = 1'b1;
            end else begin
              q_d = Q - WIDTH'(1);
            end
          end
        end
        ModeLoad: q_d = load_val;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      Q    <= RstVal;
      wrap <= 1'b0;
    end else begin
      Q    <= q_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_jk_counter_reg.sv
// Bench for jk_counter_reg: reference model plus directed vectors,
// including 800/525 and 4/3 cascaded counter chains.
module tb_jk_counter_reg;

  localparam int W = 10;
  localparam int M = 800;

  logic         clk = 1'b1;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] J = '0;
  logic [W-1:0] K = '0;
  logic [W-1:0] load_val = '0;
  logic         cnt_in = 1'b0;
  logic [W-1:0] Q;
  logic         tc;
  logic         wrap;

  // Cascade chains share mode/enable
  logic         c_en = 1'b0;
  logic [1:0]   c_mode = 2'b01;
  logic [W-1:0] c_lvh = '0;
  logic [W-1:0] c_lvv = '0;
  logic [W-1:0] zero_w = '0;
  logic [1:0]   zero_2 = '0;
  logic         one = 1'b1;
  logic [W-1:0] h_q, v_q;
  logic         h_tc, v_tc, h_wrap, v_wrap;
  logic [1:0]   sh_q, sv_q;
  logic         sh_tc, sv_tc, sh_wrap, sv_wrap;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  jk_counter_reg #(.WIDTH(W), .MODULUS(M), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .J(J), .K(K),
    .load_val(load_val), .cnt_in(cnt_in), .Q(Q), .tc(tc), .wrap(wrap)
  );

  jk_counter_reg #(.WIDTH(W), .MODULUS(800), .RST_VAL(0)) u_h (
    .clk(clk), .rst(rst), .enable(c_en), .mode(c_mode), .J(zero_w), .K(zero_w),
    .load_val(c_lvh), .cnt_in(one), .Q(h_q), .tc(h_tc), .wrap(h_wrap)
  );

  jk_counter_reg #(.WIDTH(W), .MODULUS(525), .RST_VAL(0)) u_v (
    .clk(clk), .rst(rst), .enable(c_en), .mode(c_mode), .J(zero_w), .K(zero_w),
    .load_val(c_lvv), .cnt_in(h_tc), .Q(v_q), .tc(v_tc), .wrap(v_wrap)
  );

  jk_counter_reg #(.WIDTH(2), .MODULUS(4), .RST_VAL(0)) u_sh (
    .clk(clk), .rst(rst), .enable(c_en), .mode(c_mode), .J(zero_2), .K(zero_2),
    .load_val(zero_2), .cnt_in(one), .Q(sh_q), .tc(sh_tc), .wrap(sh_wrap)
  );

  jk_counter_reg #(.WIDTH(2), .MODULUS(3), .RST_VAL(0)) u_sv (
    .clk(clk), .rst(rst), .enable(c_en), .mode(c_mode), .J(zero_2), .K(zero_2),
    .load_val(zero_2), .cnt_in(sh_tc), .Q(sv_q), .tc(sv_tc), .wrap(sv_wrap)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model of the main instance ----------------
  int m_q    = 0;
  int m_wrap = 0;

  function automatic int jk_next(input int q, input logic [W-1:0] j, input logic [W-1:0] k);
    logic [W-1:0] r;
    r = W'(q);
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        2'b11:   r[i] = ~r[i];
        default: ;
      endcase
    end
    return int'(r);
  endfunction

  function automatic int exp_tc();
    if (!enable || !cnt_in) return 0;
    if (mode == 2'b01) return (m_q + 1 >= M) ? 1 : 0;
    if (mode == 2'b10) return (m_q == 0 || m_q >= M) ? 1 : 0;
    return 0;
  endfunction

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_q    <= 0;
      m_wrap <= 0;
    end else begin
      m_wrap <= 0;
      if (enable) begin
        case (mode)
          2'b00: m_q <= jk_next(m_q, J, K);
          2'b01: if (cnt_in) begin
            if (m_q + 1 >= M) begin m_q <= 0; m_wrap <= 1; end
            else m_q <= m_q + 1;
          end
          2'b10: if (cnt_in) begin
            if (m_q == 0 || m_q >= M) begin m_q <= M - 1; m_wrap <= 1; end
            else m_q <= m_q - 1;
          end
          default: m_q <= int'(load_val);
        endcase
      end
    end
  end

  // Sampled on the rising edge, away from the falling update edge.
  always @(posedge clk) begin
    if (chk_on && rst) begin
      check("model_q", int'(Q), m_q);
      check("model_tc", int'(tc), exp_tc());
      check("model_wrap", int'(wrap), m_wrap);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] md, input logic en, input logic ci,
                       input logic [W-1:0] j, input logic [W-1:0] k,
                       input logic [W-1:0] lv);
    mode = md; enable = en; cnt_in = ci; J = j; K = k; load_val = lv;
  endtask

  initial begin
    #12;
    check("reset_q", int'(Q), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_tc", int'(tc), 0);

    // Release reset and count up
    rst = 1'b1;
    chk_on = 1'b1;
    drive(2'b01, 1, 1, '0, '0, '0);
    cyc();
    check("first_count", int'(Q), 1);
    cyc(); cyc();
    check("count_3", int'(Q), 3);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    check("async_rst_q", int'(Q), 0);
    check("async_rst_wrap", int'(wrap), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Up wrap
    drive(2'b11, 1, 1, '0, '0, 10'd798);
    cyc();
    check("load_798", int'(Q), 798);
    drive(2'b01, 1, 1, '0, '0, '0);
    #1 check("up_tc_798", int'(tc), 0);
    cyc();
    check("up_799", int'(Q), 799);
    check("up_tc_799", int'(tc), 1);
    cyc();
    check("up_wrap_q", int'(Q), 0);
    check("up_wrap_pulse", int'(wrap), 1);
    check("up_tc_0", int'(tc), 0);
    cyc();
    check("up_1", int'(Q), 1);
    check("up_wrap_clear", int'(wrap), 0);

    // Down wrap
    drive(2'b11, 1, 1, '0, '0, 10'd1);
    cyc();
    drive(2'b10, 1, 1, '0, '0, '0);
    cyc();
    check("dn_0", int'(Q), 0);
    check("dn_tc_0", int'(tc), 1);
    cyc();
    check("dn_799", int'(Q), 799);
    check("dn_wrap", int'(wrap), 1);
    cyc();
    check("dn_798", int'(Q), 798);
    check("dn_wrap_clear", int'(wrap), 0);

    // Out-of-range values
    drive(2'b11, 1, 1, '0, '0, 10'd1000);
    cyc();
    check("load_1000", int'(Q), 1000);
    drive(2'b10, 1, 1, '0, '0, '0);
    #1 check("dn_tc_oor", int'(tc), 1);
    cyc();
    check("dn_oor_799", int'(Q), 799);
    check("dn_oor_wrap", int'(wrap), 1);
    drive(2'b11, 1, 1, '0, '0, 10'd1000);
    cyc();
    drive(2'b01, 1, 1, '0, '0, '0);
    cyc();
    check("up_oor_0", int'(Q), 0);
    check("up_oor_wrap", int'(wrap), 1);

    // JK bank
    drive(2'b11, 1, 1, '0, '0, '0);
    cyc();
    drive(2'b00, 1, 1, 10'h3FF, 10'h000, '0);
    cyc();
    check("jk_set", int'(Q), 'h3FF);
    drive(2'b00, 1, 1, 10'h0F0, 10'h0F0, '0);
    cyc();
    check("jk_toggle", int'(Q), 'h30F);
    drive(2'b00, 1, 1, 10'h000, 10'h00F, '0);
    cyc();
    check("jk_clear", int'(Q), 'h300);
    drive(2'b00, 1, 1, 10'h000, 10'h000, '0);
    cyc();
    check("jk_hold", int'(Q), 'h300);
    check("jk_tc", int'(tc), 0);

    // Hold and priority
    drive(2'b11, 1, 1, '0, '0, 10'd5);
    cyc();
    drive(2'b01, 1, 1, '0, '0, '0);
    cyc();
    check("hold_pre", int'(Q), 6);
    drive(2'b01, 0, 1, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_q", int'(Q), 6);
      check("hold_tc", int'(tc), 0);
      check("hold_wrap", int'(wrap), 0);
    end
    drive(2'b01, 1, 0, '0, '0, '0);
    cyc();
    check("cnt_in0_q", int'(Q), 6);
    drive(2'b01, 0, 1, '0, '0, '0);
    #2 rst = 1'b0;
    #1 check("rst_while_hold", int'(Q), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset clears a pending wrap pulse
    drive(2'b11, 1, 1, '0, '0, 10'd799);
    cyc();
    drive(2'b01, 1, 1, '0, '0, '0);
    cyc();
    check("pre_rst_wrap", int'(wrap), 1);
    #2 rst = 1'b0;
    #1 check("rst_clears_wrap", int'(wrap), 0);
    drive(2'b01, 0, 1, '0, '0, '0);
    @(posedge clk); #1 rst = 1'b1;

    // Cascades from reset
    rst = 1'b0;
    #2 rst = 1'b1;
    c_mode = 2'b01;
    c_en   = 1'b1;
    for (int n = 1; n <= 800; n++) begin
      cyc();
      check("casc_h", int'(h_q), n % 800);
      check("casc_v", int'(v_q), n / 800);
      check("casc_v_wrap", int'(v_wrap), 0);
      check("small_h", int'(sh_q), n % 4);
      check("small_v", int'(sv_q), (n / 4) % 3);
      check("small_h_wrap", int'(sh_wrap), (n % 4 == 0) ? 1 : 0);
      check("small_v_wrap", int'(sv_wrap), (n % 12 == 0) ? 1 : 0);
    end
    // Jump near the end of the frame
    c_mode = 2'b11; c_lvh = 10'd798; c_lvv = 10'd524;
    cyc();
    c_mode = 2'b01;
    cyc();
    check("frame_h_799", int'(h_q), 799);
    check("frame_v_524", int'(v_q), 524);
    check("frame_h_tc", int'(h_tc), 1);
    check("frame_v_tc", int'(v_tc), 1);
    cyc();
    check("frame_h_0", int'(h_q), 0);
    check("frame_v_0", int'(v_q), 0);
    check("frame_v_wrap", int'(v_wrap), 1);
    cyc();
    check("frame_h_1", int'(h_q), 1);
    check("frame_v_wrap_once", int'(v_wrap), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_counter_reg.md
Name: jk_counter_reg

Overview:
- Parametrised multi-bit successor to the single JK flip-flop.
- Operates as one of:
  - a WIDTH-bit bank of independent JK bits;
  - a modulo-MODULUS up counter;
  - a modulo-MODULUS down counter;
  - a parallel-load register.
- Primary user is the VGA timing path: horizontal counter (MODULUS 800) cascaded into vertical counter (MODULUS 525) through cnt_in/tc.

Parameters:
- WIDTH, 10, register width in bits (2..16).
- MODULUS, 800, count modulus; legal range 2..2^WIDTH.
- RST_VAL, 0, value of Q after reset; must be < MODULUS.

Ports:
- clk  in  1  clock; all state updates on the falling edge, as for the existing JK flip-flop.
- rst  in  1  asynchronous, active-low reset; rst=0 forces reset immediately, independent of clk.
- enable  in  1  global update enable; 0 holds all state.
- mode  in  2  00 JK bank, 01 count up, 10 count down, 11 parallel load.
- J  in  WIDTH  per-bit J inputs (mode 00 only).
- K  in  WIDTH  per-bit K inputs (mode 00 only).
- load_val  in  WIDTH  value captured in mode 11.
- cnt_in  in  1  cascade count enable (modes 01/10 only); tie to 1 for a standalone counter.
- Q  out  WIDTH  register contents.
- tc  out  1  combinational terminal-count / carry-out to the next stage.
- wrap  out  1  registered one-cycle pulse, high for the cycle after the counter wraps.

Behaviour:
- Reset (rst=0, asynchronous): Q=RST_VAL, wrap=0. tc follows its combinational equation with Q=RST_VAL.
- Release of rst is sampled normally; the first update happens on the first falling edge with rst=1.
- Reset asserted mid-count: Q goes to RST_VAL at once; any pending wrap pulse is cleared.
- enable=0: Q holds, wrap<=0, regardless of mode, J/K, load_val or cnt_in.
- mode 00, enable=1: each bit i updates independently from {J[i],K[i]}:
  - 00 hold; 01 clear; 10 set; 11 toggle.
  - No modulus check; Q may take any WIDTH-bit value.
  - wrap<=0.
- mode 01, enable=1, cnt_in=1:
  - Q <= Q+1 if Q < MODULUS-1, else Q <= 0.
  - An out-of-range Q (>= MODULUS, e.g. left by JK or load) also goes to 0.
  - wrap<=1 on any transition to 0 by this rule, else 0.
- mode 10, enable=1, cnt_in=1:
  - Q <= Q-1 if 0 < Q < MODULUS; Q <= MODULUS-1 if Q==0 or Q >= MODULUS.
  - wrap<=1 on the transition to MODULUS-1, else 0.
- mode 01/10 with cnt_in=0: Q holds, wrap<=0.
- mode 11, enable=1: Q <= load_val; no clamping, values >= MODULUS are stored as-is; wrap<=0. cnt_in is ignored.
- tc = enable & cnt_in & ((mode==01 & Q>=MODULUS-1) | (mode==10 & (Q==0 | Q>=MODULUS))). tc is 0 in modes 00/11.
- Cascade rule: stage N+1's cnt_in connects to stage N's tc. Both stages then step on the same falling edge, so the chain acts as a synchronous counter with no ripple delay.
- Arithmetic is WIDTH bits, unsigned. For MODULUS = 2^WIDTH, the modulus compare reduces to natural overflow; no extra bit is needed.
- Mode changes take effect on the edge where the new mode is sampled; no state is kept beyond Q and wrap.
- Latency: Q and wrap are registered (one falling edge). tc has zero latency.

Test Plan:
- Reset: drive rst=0 between clock edges -> Q=0, wrap=0 immediately; release, mode=01, enable=1, cnt_in=1 -> Q=1 after the first falling edge.
- Up wrap, default params: load 798 (mode 11), then mode 01 -> Q 798, 799, 0, 1; tc=1 only while Q=799; wrap=1 only in the cycle Q=0.
- Down wrap: load 1, mode 10 -> Q 1, 0, 799, 798; tc=1 while Q=0; wrap=1 in the cycle Q=799. Load 1000 then count down -> Q=799.
- JK bank: Q=0x000; J=0x3FF, K=0x000 -> 0x3FF; J=K=0x0F0 -> 0x30F; J=0x000, K=0x00F -> 0x300; J=K=0 -> holds 0x300.
- Cascade: H instance (MODULUS 800) tc drives V instance (MODULUS 525) cnt_in, both mode 01 from reset. After 800 edges V=1, H=0. After 800*525 edges H=0, V=0, V.wrap=1 for exactly one cycle.
- Hold and priority: mid-count, enable=0 for 5 edges -> Q frozen, tc=0, wrap=0. cnt_in=0 in mode 01 -> Q frozen. rst=0 during enable=0 -> Q=RST_VAL.
